// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the GB CPU slice.
// Holds the OAM DMA state encoding and bus map constants.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_SETUP,
    DMA_XFER
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
  localparam logic [7:0]  HI_PAGE              = 8'hFF;
  localparam int          DMA_LEN_DEFAULT      = 160;
  localparam logic [7:0]  OPEN_BUS_DEFAULT     = 8'hFF;

  // Echo RAM pages E0-FF alias C0-DF.
  function automatic logic [7:0] dma_eff_hi(
    input logic [7:0] src
  );
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

endpackage

// File: rtl/gb_dma_bus_mux.sv
// CPU / OAM DMA address routing and CPU read-data mux.
// Purely combinational; ownership comes from the DMA state.
module gb_dma_bus_mux
  import gb_cpu_common_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter logic [7:0]  OPEN_BUS_VAL = OPEN_BUS_DEFAULT
) (
  input  dma_state_t  state,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  src_reg,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_we_o,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  hi_addr_o,
  output logic [7:0]  hi_data_o,
  output logic        hi_we_o,
  input  logic [7:0]  hi_data_i
);

  logic hi_sel;
  logic is_reg;
  logic own;

  always_comb begin
    hi_sel = cpu_addr_i[15:8] == HI_PAGE;
    is_reg = cpu_addr_i == DMA_REG_ADDR;
    own    = state != DMA_IDLE;

    hi_addr_o  = cpu_addr_i[7:0];
    hi_data_o  = cpu_data_i;
    hi_we_o    = cpu_we_i && hi_sel && !is_reg;

    bus_addr_o = own ? dma_addr : cpu_addr_i;
    bus_data_o = cpu_data_i;
    bus_we_o   = cpu_we_i && !hi_sel && !own;

    cpu_data_o = bus_data_i;
    unique case (1'b1)
      is_reg:            cpu_data_o = src_reg;
      hi_sel && !is_reg: cpu_data_o = hi_data_i;
      !hi_sel && own:    cpu_data_o = OPEN_BUS_VAL;
      default:           cpu_data_o = bus_data_i;
    endcase
  end

endmodule

// File: rtl/gb_oam_dma.sv
// OAM DMA controller: copies DMA_LEN bytes into OAM
// and arbitrates the main bus against the CPU.
module gb_oam_dma
  import gb_cpu_common_pkg::*;
#(
  parameter int          DMA_LEN      = DMA_LEN_DEFAULT,
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter logic [7:0]  OPEN_BUS_VAL = OPEN_BUS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_we_o,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  hi_addr_o,
  output logic [7:0]  hi_data_o,
  output logic        hi_we_o,
  input  logic [7:0]  hi_data_i,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_we_o,
  output logic        dma_active_o
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state;
  dma_state_t state_nxt;

  logic [7:0]  src_reg;
  logic [7:0]  idx;
  logic        wb_valid;
  logic [7:0]  wb_idx;
  logic [7:0]  wb_data;
  logic        trig;
  logic        xfer;
  logic [15:0] dma_addr;

  assign trig     = cpu_we_i && (cpu_addr_i == DMA_REG_ADDR);
  assign dma_addr = {dma_eff_hi(src_reg), idx};

  always_ff @(posedge clk) begin
    if (reset) state <= DMA_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DMA_IDLE:  if (trig) state_nxt = DMA_SETUP;
      DMA_SETUP: state_nxt = trig ? DMA_SETUP : DMA_XFER;
      DMA_XFER: begin
        if (trig)                 state_nxt = DMA_SETUP;
        else if (idx == LAST_IDX) state_nxt = DMA_IDLE;
      end
      default:   state_nxt = DMA_IDLE;
    endcase
  end

  always_comb begin
    xfer         = state == DMA_XFER;
    dma_active_o = xfer || wb_valid;
  end

  // Read in cycle n lands in OAM in cycle n+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg  <= 8'hFF;
      idx      <= 8'h00;
      wb_valid <= 1'b0;
      wb_idx   <= 8'h00;
      wb_data  <= 8'h00;
    end else begin
      if (trig) src_reg <= cpu_data_i;
      wb_valid <= xfer;
      if (xfer) begin
        wb_idx  <= idx;
        wb_data <= bus_data_i;
      end
      if (state == DMA_SETUP) idx <= 8'h00;
      else if (xfer)          idx <= idx + 8'h01;
    end
  end

  assign oam_we_o   = wb_valid;
  assign oam_addr_o = wb_idx;
  assign oam_data_o = wb_data;

  gb_dma_bus_mux #(
    .DMA_REG_ADDR (DMA_REG_ADDR),
    .OPEN_BUS_VAL (OPEN_BUS_VAL)
  ) u_mux (
    .state      (state),
    .dma_addr   (dma_addr),
    .src_reg    (src_reg),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_data_o (cpu_data_o),
    .bus_addr_o (bus_addr_o),
    .bus_data_o (bus_data_o),
    .bus_we_o   (bus_we_o),
    .bus_data_i (bus_data_i),
    .hi_addr_o  (hi_addr_o),
    .hi_data_o  (hi_data_o),
    .hi_we_o    (hi_we_o),
    .hi_data_i  (hi_data_i)
  );

endmodule

// File: tb/tb_gb_oam_dma.sv
// Randomized bench for gb_oam_dma against a
// per-cycle schedule model of DMA transfers.
module tb_gb_oam_dma;

  localparam int LEN = 160;
  localparam int NC  = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_we_i;
  logic [7:0]  cpu_data_o;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic        bus_we_o;
  logic [7:0]  bus_data_i;
  logic [7:0]  hi_addr_o;
  logic [7:0]  hi_data_o;
  logic        hi_we_o;
  logic [7:0]  hi_data_i;
  logic [7:0]  oam_addr_o;
  logic [7:0]  oam_data_o;
  logic        oam_we_o;
  logic        dma_active_o;

  logic [7:0] mem [65536];
  logic [7:0] hi_mem [256];

  assign bus_data_i = mem[bus_addr_o];
  assign hi_data_i  = hi_mem[hi_addr_o];

  always #5 clk = ~clk;

  gb_oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_data_o   (cpu_data_o),
    .bus_addr_o   (bus_addr_o),
    .bus_data_o   (bus_data_o),
    .bus_we_o     (bus_we_o),
    .bus_data_i   (bus_data_i),
    .hi_addr_o    (hi_addr_o),
    .hi_data_o    (hi_data_o),
    .hi_we_o      (hi_we_o),
    .hi_data_i    (hi_data_i),
    .oam_addr_o   (oam_addr_o),
    .oam_data_o   (oam_data_o),
    .oam_we_o     (oam_we_o),
    .dma_active_o (dma_active_o)
  );

  // Schedule model: what each absolute cycle should show.
  bit          rd_v [NC];
  logic [15:0] rd_a [NC];
  bit          own_v [NC];
  bit          wr_v [NC];
  logic [7:0]  wr_i [NC];
  logic [7:0]  wr_d [NC];
  logic [7:0]  m_src;
  int          cyc;
  bit          checking;
  int          n_tests;
  int          n_fail;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] eff(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  task automatic model_trigger(input int t, input logic [7:0] s);
    for (int c = t + 1; c < NC; c++) begin
      rd_v[c]  = 1'b0;
      own_v[c] = 1'b0;
      if (c > t + 1) wr_v[c] = 1'b0;
    end
    for (int c = t + 1; c <= t + 1 + LEN && c < NC; c++)
      own_v[c] = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      int c;
      c = t + 2 + i;
      if (c + 1 < NC) begin
        rd_v[c]     = 1'b1;
        rd_a[c]     = {eff(s), 8'(i)};
        wr_v[c + 1] = 1'b1;
        wr_i[c + 1] = 8'(i);
        wr_d[c + 1] = mem[{eff(s), 8'(i)}];
      end
    end
  endtask

  task automatic model_reset(input int r);
    for (int c = r + 1; c < NC; c++) begin
      rd_v[c]  = 1'b0;
      own_v[c] = 1'b0;
      wr_v[c]  = 1'b0;
    end
    m_src = 8'hFF;
  endtask

  task automatic step(
    input logic [15:0] a,
    input logic [7:0]  d,
    input logic        we,
    input logic        rst
  );
    @(negedge clk);
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_we_i   = we;
    reset      = rst;
    #1;
    if (checking) begin
      check("oam_we", 16'(oam_we_o), 16'(wr_v[cyc]));
      if (wr_v[cyc]) begin
        check("oam_addr", 16'(oam_addr_o), 16'(wr_i[cyc]));
        check("oam_data", 16'(oam_data_o), 16'(wr_d[cyc]));
      end
      check("dma_active", 16'(dma_active_o),
            16'(rd_v[cyc] || wr_v[cyc]));
      if (rd_v[cyc]) check("dma_addr", bus_addr_o, rd_a[cyc]);
      if (a == 16'hFF46) begin
        check("reg_hi_we", 16'(hi_we_o), 16'h0);
        check("reg_bus_we", 16'(bus_we_o), 16'h0);
        if (!we) check("reg_rd", 16'(cpu_data_o), 16'(m_src));
      end else if (a[15:8] == 8'hFF) begin
        check("hi_addr", 16'(hi_addr_o), 16'(a[7:0]));
        check("hi_we", 16'(hi_we_o), 16'(we));
        check("hi_bus_we", 16'(bus_we_o), 16'h0);
        if (we) check("hi_wdata", 16'(hi_data_o), 16'(d));
        else check("hi_rd", 16'(cpu_data_o), 16'(hi_mem[a[7:0]]));
      end else begin
        check("lo_hi_we", 16'(hi_we_o), 16'h0);
        if (own_v[cyc]) begin
          check("blk_we", 16'(bus_we_o), 16'h0);
          if (!we) check("open_bus", 16'(cpu_data_o), 16'h00FF);
        end else begin
          check("bus_addr", bus_addr_o, a);
          check("bus_we", 16'(bus_we_o), 16'(we));
          if (we) check("bus_wdata", 16'(bus_data_o), 16'(d));
          else check("bus_rd", 16'(cpu_data_o), 16'(mem[a]));
        end
      end
    end
    if (rst) model_reset(cyc);
    else if (we && a == 16'hFF46) begin
      model_trigger(cyc, d);
      m_src = d;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic rand_acc(
    output logic [15:0] a,
    output logic [7:0]  d,
    output logic        we
  );
    int k;
    k  = int'($urandom_range(0, 3));
    d  = 8'($urandom);
    we = 1'($urandom_range(0, 1));
    case (k)
      0: begin
        a = {8'hFF, 8'($urandom)};
        if (a == 16'hFF46) a = 16'hFF47;
      end
      1: begin
        a  = 16'hFF46;
        we = 1'b0;
      end
      default: a = 16'($urandom_range(0, 16'hFEFF));
    endcase
  endtask

  task automatic run(input int n);
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
    for (int i = 0; i < n; i++) begin
      rand_acc(a, d, we);
      step(a, d, we, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    checking = 1'b0;
    m_src    = 8'hFF;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) hi_mem[i] = 8'($urandom);
    reset      = 1'b1;
    cpu_addr_i = 16'h0;
    cpu_data_i = 8'h0;
    cpu_we_i   = 1'b0;
    step(16'h0, 8'h0, 1'b0, 1'b1);
    step(16'h0, 8'h0, 1'b0, 1'b1);
    checking = 1'b1;

    step(16'hFF46, 8'h00, 1'b0, 1'b0);
    step(16'hFF40, 8'h99, 1'b1, 1'b0);
    step(16'hC000, 8'hAB, 1'b1, 1'b0);
    run(10);

    step(16'hFF46, 8'hC1, 1'b1, 1'b0);
    run(165);

    step(16'hFF46, 8'hE3, 1'b1, 1'b0);
    step(16'hFF85, 8'h00, 1'b0, 1'b0);
    step(16'h8000, 8'h00, 1'b0, 1'b0);
    step(16'hC000, 8'h55, 1'b1, 1'b0);
    run(170);
    step(16'hFF46, 8'h00, 1'b0, 1'b0);

    step(16'hFF46, 8'hC0, 1'b1, 1'b0);
    run(41);
    step(16'hFF46, 8'hD0, 1'b1, 1'b0);
    run(170);

    step(16'hFF46, 8'($urandom), 1'b1, 1'b0);
    step(16'hFF46, 8'($urandom), 1'b1, 1'b0);
    run(170);

    step(16'hFF46, 8'($urandom), 1'b1, 1'b0);
    run(78);
    step(16'h2000, 8'h00, 1'b0, 1'b1);
    step(16'h1234, 8'h00, 1'b0, 1'b0);
    step(16'hFF46, 8'h00, 1'b0, 1'b0);
    run(5);

    for (int i = 0; i < 700; i++) begin
      rand_acc(a, d, we);
      if ($urandom_range(0, 149) == 0) begin
        a  = 16'hFF46;
        we = 1'b1;
      end
      step(a, d, we, $urandom_range(0, 299) == 0);
    end
    run(170);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma.md
Name: gb_oam_dma

Overview:
- OAM DMA controller and bus arbiter between the CPU core (addr_o/data_o/drive_data_bus/data_i) and the memory system.
- A CPU write to 0xFF46 copies 160 bytes from {src_hi,8'h00} into OAM through a dedicated OAM write port.
- While the copy runs, the block owns the main bus. CPU accesses outside 0xFF00-0xFFFF are blocked; accesses inside that range go to the high (I/O/HRAM) port.

Parameters:
DMA_LEN, 160, bytes per transfer (max 256).
DMA_REG_ADDR, 16'hFF46, address of the DMA source register.
OPEN_BUS_VAL, 8'hFF, value returned to blocked CPU reads.

Ports:
clk  in  1  M-cycle clock
reset  in  1  reset
cpu_addr_i  in  16  CPU address bus
cpu_data_i  in  8  CPU write data
cpu_we_i  in  1  CPU drive_data_bus
cpu_data_o  out  8  read data returned to CPU data_i
bus_addr_o  out  16  main bus address (0x0000-0xFEFF space)
bus_data_o  out  8  main bus write data
bus_we_o  out  1  main bus write enable
bus_data_i  in  8  main bus read data (combinational, same cycle)
hi_addr_o  out  8  high port offset (addr - 0xFF00)
hi_data_o  out  8  high port write data
hi_we_o  out  1  high port write enable
hi_data_i  in  8  high port read data
oam_addr_o  out  8  OAM byte index
oam_data_o  out  8  OAM write data
oam_we_o  out  1  OAM write enable
dma_active_o  out  1  transfer in progress (PPU locks OAM)

Behaviour:
- Clocking: all state on posedge clk. Reset is synchronous and active-high, and wins over everything, including a transfer in progress.
- Reset values: state IDLE, src_reg 8'hFF, idx 0, wb_valid 0. Outputs oam_we_o=0, dma_active_o=0, bus_we_o=0, hi_we_o=0.
- DMA trigger (cycle T): cpu_we_i && cpu_addr_i==DMA_REG_ADDR.
  - Store src_reg <= cpu_data_i.
  - The write is not forwarded to the high port.
  - A CPU read of DMA_REG_ADDR returns src_reg locally.
- Source mapping: eff_hi = (src_reg >= 8'hE0) ? src_reg - 8'h20 : src_reg.
- States:
  - IDLE: the CPU passes through.
    - cpu_addr_i[15:8]==FF goes to the high port; everything else goes to the main bus.
    - cpu_data_o is muxed from the selected port.
  - SETUP (cycle T+1): no new read is started. idx is cleared to 0 at the end of the cycle. The next state is XFER.
  - XFER (cycles T+2 .. T+1+DMA_LEN):
    - bus_addr_o = {eff_hi, idx}, bus_we_o=0.
    - The byte is captured into wb_data and wb_idx=idx, with wb_valid=1.
    - idx increments each cycle. After the idx==DMA_LEN-1 read, go to IDLE.
- OAM write pipeline: in the cycle after each read, oam_we_o=wb_valid, oam_addr_o=wb_idx, oam_data_o=wb_data.
  - The last OAM write (index DMA_LEN-1) occurs at T+2+DMA_LEN, while the state is already IDLE.
  - There are exactly DMA_LEN OAM writes per completed transfer.
- dma_active_o: high during XFER and during any cycle with wb_valid=1. It is low in SETUP for a fresh start.
- CPU arbitration while in XFER:
  - CPU access to 0xFF00-0xFFFF uses the high port normally and concurrently with the DMA.
  - Any other CPU read returns OPEN_BUS_VAL.
  - Any other CPU write is dropped (bus_we_o stays 0).
- Restart: a trigger during XFER enters a restart SETUP.
  - The old transfer performs one more read with the old eff_hi and idx during that cycle, using the pre-write eff_hi.
  - Then idx=0 with the new source. dma_active_o stays high throughout.
- Trigger during SETUP: the new src_reg value is used, and one SETUP cycle restarts from that write.
- Reset mid-transfer: the transfer is abandoned next cycle with no further OAM writes. The pending wb_valid is cleared.

Decomposition:
- Add to gb_cpu_common_pkg:
  - dma_state_t enum (DMA_IDLE, DMA_SETUP, DMA_XFER)
  - DMA_REG_ADDR_DEFAULT
  - HI_PAGE constant 8'hFF
- Sub-module gb_dma_bus_mux is natural: combinational CPU/DMA address routing and read-data mux, driven by state. The FSM, counter and write-back pipeline stay in gb_oam_dma.

Test Plan:
1. CPU writes 0xC1 to 0xFF46 at T, with main memory holding byte = low address ^ 0x5A → OAM writes at T+3..T+162 with oam_addr 0..159 and data {i}^0x5A; dma_active_o high T+2..T+162, low at T+1 and T+163.
2. Write 0xE3 to 0xFF46 → bus_addr_o runs 0xC300..0xC39F; a subsequent CPU read of 0xFF46 returns 0xE3.
3. During XFER: CPU reads 0xFF85 (hi_data_i=0x3C) → cpu_data_o=0x3C; CPU reads 0x8000 → 0xFF; CPU writes 0xC000 → bus_we_o stays 0, bus_addr_o keeps DMA address.
4. At idx=40 of source 0xC0, CPU writes 0xD0 to 0xFF46 → one read at 0xC028, then the next read is 0xD000; 161+ total OAM writes with the final 160 from 0xD0xx.
5. Assert reset at idx=77 → next cycle oam_we_o=0, dma_active_o=0, src_reg=0xFF; CPU access to 0x1234 is passed through in the cycle after reset deasserts.
6. Idle passthrough: CPU writes 0x99 to 0xFF40 → hi_we_o=1, hi_addr_o=0x40; CPU writes 0xAB to 0xC000 → bus_we_o=1, bus_data_o=0xAB; no OAM activity.
